// File: rtl/adc_vi_sampler.sv
// adc_vi_sampler: paces pairs of SPI conversions (voltage channel, then current
// channel). It converts each 12-bit raw result to output format and presents
// both values together with a single-cycle valid strobe.
module adc_vi_sampler #(
  parameter int CLK_DIV       = 1,   // SCLK half-period in clk cycles (1..15)
  parameter int SAMPLE_PERIOD = 96   // clk cycles between pair starts
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_csn,
  output logic        adc_sclk,
  output logic        adc_mosi,
  input  logic        adc_miso,
  output logic        valid_out,
  output logic [11:0] v_out,
  output logic [11:0] i_out
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic          chan_q, chan_d;        // 0 = voltage frame, 1 = current frame
  logic [PW-1:0] period_q, period_d;
  logic [3:0]    div_q, div_d;          // clk count inside one SCLK half-period
  logic          phase_q, phase_d;      // SCLK level while shifting
  logic [3:0]    bit_q, bit_d;          // SCLK period index 0..15
  logic          gap_q, gap_d;          // second GAP cycle flag
  logic [11:0]   shift_q, shift_d;      // last 12 MISO samples, MSB first
  logic [11:0]   vbuf_q, vbuf_d;        // converted V result awaiting the I frame
  logic [11:0]   v_q, v_d, i_q, i_d;
  logic          valid_q, valid_d;
  logic          csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d;

  // Offset-binary style conversion: positive codes pass, others invert the magnitude.
  function automatic logic [11:0] fmt(input logic [11:0] raw);
    return raw[11] ? raw : {1'b0, raw[10:0] ^ 11'h7FF};
  endfunction

  // Next-state, datapath and pin decode; pins are registered from the next state.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    period_d = (period_q != '0) ? period_q - PW'(1) : '0;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    shift_d  = shift_q;
    vbuf_d   = vbuf_q;
    v_d      = v_q;
    i_d      = i_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && period_q == '0) begin
          state_d  = SETUP;
          chan_d   = 1'b0;
          period_d = PW'(SAMPLE_PERIOD - 1);
        end
      end
      SETUP: begin
        state_d = SHIFT;
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (div_q == 4'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            // SCLK rises on this edge: capture MISO now.
            phase_d = 1'b1;
            shift_d = {shift_q[10:0], adc_miso};
          end else begin
            phase_d = 1'b0;
            if (bit_q == 4'd15) state_d = HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      HOLD: begin
        state_d = GAP;
        gap_d   = 1'b0;
        if (chan_q) begin
          v_d     = vbuf_q;
          i_d     = fmt(shift_q);
          valid_d = 1'b1;
        end else begin
          vbuf_d  = fmt(shift_q);
        end
      end
      GAP: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if (!chan_q) begin
          chan_d  = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    csn_d  = !(state_d inside {SETUP, SHIFT, HOLD});
    sclk_d = (state_d == SHIFT) && phase_d;
    // Frame word is {2'b00, chan, 13'b0}: only bit index 2 can be non-zero.
    mosi_d = (state_d == SHIFT) && (bit_d == 4'd2) && chan_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      chan_q   <= 1'b0;
      period_q <= '0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      gap_q    <= 1'b0;
      shift_q  <= '0;
      vbuf_q   <= 12'h7FF;
      v_q      <= 12'h7FF;
      i_q      <= 12'h7FF;
      valid_q  <= 1'b0;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      period_q <= period_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      vbuf_q   <= vbuf_d;
      v_q      <= v_d;
      i_q      <= i_d;
      valid_q  <= valid_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
    end
  end

  assign adc_csn   = csn_q;
  assign adc_sclk  = sclk_q;
  assign adc_mosi  = mosi_q;
  assign valid_out = valid_q;
  assign v_out     = v_q;
  assign i_out     = i_q;

endmodule

// File: tb/tb_adc_vi_sampler.sv
// Bench for adc_vi_sampler: two instances (default period, and a period shorter
// than a pair), each with an SPI ADC model and a reference monitor.
module tb_adc_vi_sampler;

  localparam int FRAME = 4 + 32;          // CLK_DIV = 1
  localparam int LAT   = 2 * FRAME - 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic rst_s = 1'b1, en_s = 1'b0;        // values the DUT saw at the last edge
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;

  logic        force_en = 1'b0;
  logic [11:0] force_v = '0, force_i = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_s <= reset;
    en_s  <= enable;
    cyc   <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected output format, from the signed-magnitude-style rule.
  function automatic logic [11:0] ref_fmt(input logic [11:0] raw);
    if (raw >= 12'h800) return raw;
    return 12'h7FF - raw;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int SP  = (gi == 0) ? 96 : 40;
    localparam int PER = (SP > 2 * FRAME) ? SP : 2 * FRAME + 1;

    logic        csn, sclk, mosi, miso, valid;
    logic [11:0] v, i;

    adc_vi_sampler #(.CLK_DIV(1), .SAMPLE_PERIOD(SP)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .adc_csn(csn), .adc_sclk(sclk), .adc_mosi(mosi), .adc_miso(miso),
      .valid_out(valid), .v_out(v), .i_out(i)
    );

    logic        prev_csn = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic        exp_chan = 1'b0, frame_chan = 1'b0, valid_exp;
    logic        pair_open = 1'b0, en_gap = 1'b1;
    logic [15:0] rx = '0, junk = '0;
    logic [11:0] raw_v = '0, raw_i = '0, raw_cur = '0;
    logic [11:0] exp_v = 12'h7FF, exp_i = 12'h7FF, pend_v = 12'h7FF;
    int          idx = 0, rises = 0, low_cnt = 0, high_cnt = 2;
    int          v_fall = 0, last_strobe = -1, n_strobe = 0, low_total = 0;

    // ADC model plus reference monitor, evaluated away from the active edge.
    always @(negedge clk) begin
      valid_exp = 1'b0;
      if (rst_s) begin
        check("rst_csn", csn, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_valid", valid, 0);
        check("rst_v", v, 12'h7FF);
        check("rst_i", i, 12'h7FF);
        exp_v = 12'h7FF; exp_i = 12'h7FF; exp_chan = 1'b0;
        pair_open = 1'b0; last_strobe = -1; high_cnt = 2;
      end else begin
        if (prev_csn && !csn) begin
          frame_chan = exp_chan;
          rises = 0; idx = 0; low_cnt = 0; rx = '0;
          junk = 16'($urandom);
          if (!frame_chan) begin
            check("start_enable", en_s, 1);
            v_fall    = cyc;
            pair_open = 1'b1;
            raw_v     = force_en ? force_v : 12'($urandom);
            raw_i     = force_en ? force_i : 12'($urandom);
          end else begin
            check("gap_len", high_cnt, 2);
          end
        end
        if (!csn) begin
          low_cnt++;
          low_total++;
          if (prev_sclk && !sclk) idx++;
          if (!prev_sclk && sclk) begin
            rx = {rx[14:0], mosi};
            rises++;
            if (rises == 3) raw_cur = rx[0] ? raw_i : raw_v;
          end
          if (mosi !== prev_mosi) check("mosi_edge", sclk, 0);
        end
        if (!prev_csn && csn) begin
          check("sclk_rises", rises, 16);
          check("csn_low", low_cnt, FRAME - 2);
          check("mosi_word", rx, {2'b00, frame_chan, 13'b0});
          if (!frame_chan) begin
            pend_v   = ref_fmt(raw_v);
            exp_chan = 1'b1;
          end else begin
            valid_exp = 1'b1;
            exp_v     = pend_v;
            exp_i     = ref_fmt(raw_i);
            exp_chan  = 1'b0;
          end
          high_cnt = 0;
        end
        if (csn) high_cnt++;
        check("valid", valid, valid_exp);
        check("v_out", v, exp_v);
        check("i_out", i, exp_i);
        if (valid_exp) begin
          $display("strobe inst%0d cyc=%0d v=%h i=%h", gi, cyc, v, i);
          check("latency", cyc - v_fall, LAT);
          if (last_strobe >= 0 && !en_gap) check("period", cyc - last_strobe, PER);
          last_strobe = cyc;
          en_gap      = 1'b0;
          pair_open   = 1'b0;
          n_strobe++;
        end
        if (!en_s) en_gap = 1'b1;
      end
      // Data shifts out on SCLK falls; top four bits of the word are don't-care.
      if (!csn && idx >= 4 && idx < 16) miso = raw_cur[15-idx];
      else                              miso = junk[idx[3:0]];
      prev_csn  = csn;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic wait_valid0(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (g_inst[0].valid) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_csn_fall0(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (!g_inst[0].csn) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int s0, l0, l1;
    step(3);
    reset = 1'b0;

    // Directed pair: V raw 0x123, I raw 0x456.
    force_en = 1'b1; force_v = 12'h123; force_i = 12'h456;
    enable = 1'b1;
    wait_valid0("wait_pair1");
    check("dir_v_123", g_inst[0].v, 12'h6DC);
    check("dir_i_456", g_inst[0].i, 12'h3A9);

    // Boundary codes: V raw 0x000, I raw 0x800.
    force_v = 12'h000; force_i = 12'h800;
    wait_valid0("wait_pair2");
    wait_valid0("wait_pair3");
    check("dir_v_000", g_inst[0].v, 12'h7FF);
    check("dir_i_800", g_inst[0].i, 12'h800);

    // Sustained random sampling.
    force_en = 1'b0;
    step(1000);

    // Enable drops during the V frame: the pair must still complete.
    wait_valid0("wait_pre_drop");
    wait_csn_fall0("wait_v_frame");
    s0 = g_inst[0].n_strobe;
    step(9);
    enable = 1'b0;
    step(200);
    check("drop_one_strobe", g_inst[0].n_strobe - s0, 1);
    check("drop_pair_done0", g_inst[0].pair_open, 0);
    check("drop_pair_done1", g_inst[1].pair_open, 0);
    l0 = g_inst[0].low_total; l1 = g_inst[1].low_total;
    step(100);
    check("idle_csn0", g_inst[0].low_total - l0, 0);
    check("idle_csn1", g_inst[1].low_total - l1, 0);

    // Re-enable while idle with the counter expired: start next cycle.
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_csn0", g_inst[0].csn, 0);
    check("restart_csn1", g_inst[1].csn, 0);

    // Reset during the I-frame shift.
    wait_valid0("wait_pre_rst");
    wait_csn_fall0("wait_v_rst");
    @(negedge clk);
    while (!g_inst[0].csn) @(negedge clk);
    wait_csn_fall0("wait_i_rst");
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_csn", g_inst[0].csn, 1);
    check("abort_v", g_inst[0].v, 12'h7FF);
    check("abort_i", g_inst[0].i, 12'h7FF);

    // Random enable activity with occasional resets.
    for (int r = 0; r < 8; r++) begin
      enable = 1'($urandom_range(0, 1));
      step($urandom_range(50, 300));
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
    end

    enable = 1'b0;
    step(250);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
